// File: rtl/opb_reg_pkg.sv
// Shared types, register offsets and byte-merge helper for the
// OPB register slaves.
package opb_reg_pkg;

    typedef enum logic {
        IDLE,
        ACK
    } state_t;

    localparam logic [5:0] OFS_DATA  = 6'd0;
    localparam logic [5:0] OFS_WRCNT = 6'd1;

    // be[0] selects bits [7:0] (little-endian lane order)
    function automatic logic [31:0] be_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                r[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/opb_register_ppc2simulink_sync_if.sv
// OPB bus bundle between a bus master and the ppc2simulink
// register slave.
interface opb_register_ppc2simulink_sync_if;

    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus,
        output OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck,
        input  Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus,
        input  OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck,
        output Sl_retry, Sl_toutSup
    );

endinterface

// File: rtl/opb_be_merge.sv
// Byte-enable merge of OPB write data into a user-ordered register.
// OPB bit 0 / BE[0] map onto user bit 31 / the top byte.
module opb_be_merge
    import opb_reg_pkg::*;
(
    input  logic [31:0] old_data,
    input  logic [0:31] wr_data,
    input  logic [0:3]  be,
    output logic [31:0] merged
);

    logic [31:0] wr_user;
    logic [3:0]  be_user;

    assign wr_user = wr_data;

    always_comb begin
        be_user = '0;
        for (int b = 0; b < 4; b++) begin
            be_user[3-b] = be[b];
        end
    end

    assign merged = be_merge(old_data, wr_user, be_user);

endmodule

// File: rtl/opb_register_ppc2simulink_sync.sv
// OPB slave register: PowerPC writes a control word into fabric,
// with an update strobe and a read-only write counter.
module opb_register_ppc2simulink_sync
    import opb_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0100_1300,
    parameter logic [31:0] C_HIGHADDR   = 32'h0100_13FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex5",
    parameter logic [31:0] C_INIT_VALUE = 32'h0000_0000
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst_n,
    opb_register_ppc2simulink_sync_if.slave bus,
    output logic [31:0] user_data_out,
    output logic        user_data_upd
);

    if (C_OPB_DWIDTH != 32 || C_OPB_AWIDTH != 32) begin : g_bad_width
        $error("only 32-bit OPB is supported");
    end

    localparam int unused_family_len = $bits(C_FAMILY);

    state_t      state;
    logic        hit;
    logic [5:0]  ofs;
    logic [31:0] data_q;
    logic [31:0] wr_count;
    logic [31:0] merged;
    logic [31:0] rd_val;
    logic [31:0] dbus_q;
    logic        ack_q;
    logic        upd_q;
    logic        unused;

    assign unused = bus.OPB_seqAddr;

    assign hit = bus.OPB_select
               & (bus.OPB_ABus >= C_BASEADDR)
               & (bus.OPB_ABus <= C_HIGHADDR);
    assign ofs = bus.OPB_ABus[24:29];

    opb_be_merge u_merge (
        .old_data (data_q),
        .wr_data  (bus.OPB_DBus),
        .be       (bus.OPB_BE),
        .merged   (merged)
    );

    always_comb begin
        rd_val = '0;
        case (ofs)
            OFS_DATA:  rd_val = data_q;
            OFS_WRCNT: rd_val = wr_count;
            default:   rd_val = '0;
        endcase
    end

    // Sl_DBus is cleared every cycle so it is only non-zero during ACK
    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n) begin
            state    <= IDLE;
            ack_q    <= 1'b0;
            dbus_q   <= '0;
            upd_q    <= 1'b0;
            data_q   <= C_INIT_VALUE;
            wr_count <= '0;
        end else begin
            ack_q  <= 1'b0;
            dbus_q <= '0;
            upd_q  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (hit) begin
                        state <= ACK;
                        ack_q <= 1'b1;
                        if (bus.OPB_RNW) begin
                            dbus_q <= rd_val;
                        end else if (ofs == OFS_DATA) begin
                            data_q   <= merged;
                            wr_count <= wr_count + 32'd1;
                            upd_q    <= 1'b1;
                        end
                    end
                end
                ACK: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Sl_DBus    = dbus_q;
    assign bus.Sl_xferAck = ack_q;
    assign bus.Sl_errAck  = 1'b0;
    assign bus.Sl_retry   = 1'b0;
    assign bus.Sl_toutSup = 1'b0;

    assign user_data_out = data_q;
    assign user_data_upd = upd_q;

endmodule
